pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the pipeline control-vector registers of the 8-bit RAT pipeline.
//  - Decides each cycle whether IF/ID holds, the ID/EX stage gets a bubble (nop),
//    IF/ID is flushed, or the interrupt control vector is injected.
//  - Handles load-use stalls, taken-branch flushes and interrupt entry (drain -> inject -> redirect).
//  - Keeps a saturating stall-cycle counter for debug.
// PARAMETERS
//  RF_ADDR_W      5   register-file address width
//  FLUSH_DEPTH    2   bubbles inserted after a taken branch resolves in EX (1..3)
//  INT_DRAIN      2   cycles of drain before interrupt injection (1..3)
//  CNT_W          16  width of stall_count
// PORTS
//  clk            in   1          rising-edge clock
//  rst            in   1          reset: asynchronous, active-high
//  id_x_addr      in   RF_ADDR_W  ID-stage source X register
//  id_x_used      in   1          ID instruction reads X
//  id_y_addr      in   RF_ADDR_W  ID-stage source Y register
//  id_y_used      in   1          ID instruction reads Y
//  ex_rf_wr       in   1          EX instruction writes the RF
//  ex_is_load     in   1          EX instruction's RF data comes from scratch RAM / IN port
//  ex_wb_addr     in   RF_ADDR_W  EX destination register
//  ex_br_taken    in   1          branch resolved taken in EX this cycle
//  int_req        in   1          level: interrupt pending and I flag set
//  stall_if       out  1          hold PC and the IF/ID register
//  flush_if_id    out  1          load nop into the IF/ID register
//  nop_id_ex      out  1          drives the nop input of the ID/EX control-vector register
//  int_inject     out  1          drives the interrupt input of the ID/EX control-vector register
//  int_ack        out  1          one-cycle acknowledge to the interrupt source
//  busy           out  1          FSM is not in RUN
//  stall_count    out  CNT_W      cycles with stall_if=1 (saturating)
// BEHAVIOUR
//  - Outputs are combinational from state and the current inputs.
//    State, counters and stall_count are registered.
//  - While rst=1 (asynchronous): state=RUN, cnt=0, stall_count=0;
//    stall_if=1, nop_id_ex=1, flush_if_id=1, int_inject=0, int_ack=0, busy=0.
//  - hazard = ex_rf_wr & ex_is_load & ((id_x_used & id_x_addr==ex_wb_addr) | (id_y_used & id_y_addr==ex_wb_addr)).
//    All addresses including r0 compare.
//  - Priority each cycle: ex_br_taken > int_req > hazard.
//  - States:
//    RUN:       br_taken -> flush_if_id=1, nop_id_ex=1; cnt<=FLUSH_DEPTH-1; go FLUSH (RUN again if FLUSH_DEPTH=1).
//               else int_req -> stall_if=1, nop_id_ex=1; cnt<=INT_DRAIN-1; go DRAIN (INJECT if INT_DRAIN=1).
//               else hazard -> stall_if=1, nop_id_ex=1 for exactly this cycle; stay RUN.
//               else all outputs 0.
//    FLUSH:     flush_if_id=1, nop_id_ex=1; cnt decrements; go RUN after cnt==0.
//               br_taken here is ignored, since EX holds a bubble.
//    DRAIN:     stall_if=1, nop_id_ex=1.
//               br_taken (older instruction still in EX) -> abort: go FLUSH as from RUN, no int_ack.
//               int_req remains pending and is re-evaluated in RUN.
//               else cnt decrements; go INJECT after cnt==0.
//    INJECT:    int_inject=1, int_ack=1, stall_if=1; go REDIRECT. int_req is not re-sampled.
//    REDIRECT:  flush_if_id=1, nop_id_ex=1 (PC now holds vector 0x3FF); go RUN.
//  - int_req deasserting during DRAIN: the drain still completes and injects.
//    The source has committed once it is sampled in RUN.
//  - busy = (state != RUN).
//  - stall_count increments on every cycle with stall_if=1 and holds at all ones.
//  - If rst asserts mid-sequence, any partially drained interrupt is dropped.
//    No int_ack is issued for it.
// STRUCTURE
//  - Shared package rat_pipe_pkg:
//    - typedef enum logic[2:0] {RUN, FLUSH, DRAIN, INJECT, REDIRECT} hz_state_t;
//    - localparam INT_VECTOR = 10'h3FF;
//    - RF address width constant.
//  - One sub-module: load_use_detect (combinational hazard compare).
//    Everything else is inline; no further hierarchy.
// TESTING
//  - Reset mid-DRAIN: rst pulse -> outputs reset values immediately; after release state=RUN; int_ack never seen.
//  - Load-use: ex_rf_wr=1, ex_is_load=1, ex_wb_addr=5, id_x_used=1, id_x_addr=5 -> stall_if and nop_id_ex high for 1 cycle.
//    Same with ex_is_load=0 -> no stall.
//  - Branch: ex_br_taken=1 in RUN, FLUSH_DEPTH=2 -> flush_if_id high 2 cycles, then RUN; busy high for 1 cycle.
//  - Interrupt: int_req=1, INT_DRAIN=2 -> stall 2 cycles, int_inject+int_ack on cycle 3, flush on cycle 4, RUN on cycle 5.
//  - Branch during DRAIN: int_req=1, then ex_br_taken=1 on drain cycle 1 -> FLUSH, no ack.
//    int_req held -> full interrupt sequence follows.
//  - Counter: force CNT_W=4 with 20 hazard cycles -> stall_count saturates at 15.
//    Simultaneous br_taken+int_req+hazard -> branch flush wins.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and constants for the RAT pipeline control sequencer
package rat_pipe_pkg;
  localparam int RF_ADDR_W = 5;
  localparam logic [9:0] INT_VECTOR = 10'h3FF;
  typedef enum logic [2:0] {RUN, FLUSH, DRAIN, INJECT, REDIRECT} hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status in, control-vector register commands out
interface pipeline_hazard_ctrl_if #(
  parameter int RF_ADDR_W = rat_pipe_pkg::RF_ADDR_W,
  parameter int CNT_W = 16
);
  logic [RF_ADDR_W-1:0] id_x_addr, id_y_addr, ex_wb_addr;
  logic id_x_used, id_y_used, ex_rf_wr, ex_is_load, ex_br_taken, int_req;
  logic stall_if, flush_if_id, nop_id_ex, int_inject, int_ack, busy;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_x_addr, id_x_used, id_y_addr, id_y_used, ex_rf_wr, ex_is_load, ex_wb_addr, ex_br_taken, int_req,
    input stall_if, flush_if_id, nop_id_ex, int_inject, int_ack, busy, stall_count
  );
  modport slave (
    input id_x_addr, id_x_used, id_y_addr, id_y_used, ex_rf_wr, ex_is_load, ex_wb_addr, ex_br_taken, int_req,
    output stall_if, flush_if_id, nop_id_ex, int_inject, int_ack, busy, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID source register that a load in EX has not yet produced
module load_use_detect #(
  parameter int RF_ADDR_W = 5
) (
  input  logic [RF_ADDR_W-1:0] x_addr,
  input  logic                 x_used,
  input  logic [RF_ADDR_W-1:0] y_addr,
  input  logic                 y_used,
  input  logic                 ex_rf_wr,
  input  logic                 ex_is_load,
  input  logic [RF_ADDR_W-1:0] wb_addr,
  output logic                 hazard
);
  assign hazard = ex_rf_wr & ex_is_load & ((x_used & (x_addr == wb_addr)) | (y_used & (y_addr == wb_addr)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and interrupt entry sequencing
module pipeline_hazard_ctrl import rat_pipe_pkg::*; #(
  parameter int RF_ADDR_W = rat_pipe_pkg::RF_ADDR_W,
  parameter int FLUSH_DEPTH = 2,
  parameter int INT_DRAIN = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] FD1 = 2'(FLUSH_DEPTH - 1);
  localparam logic [1:0] ID1 = 2'(INT_DRAIN - 1);
  localparam hz_state_t BR_ST = (FLUSH_DEPTH == 1) ? RUN : FLUSH;
  localparam hz_state_t INT_ST = (INT_DRAIN == 1) ? INJECT : DRAIN;
  hz_state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [CNT_W-1:0] stall_count;
  logic hazard, last, run_flush, run_stall;
  load_use_detect #(.RF_ADDR_W(RF_ADDR_W)) u_load_use_detect (
    .x_addr(hz.id_x_addr), .x_used(hz.id_x_used),
    .y_addr(hz.id_y_addr), .y_used(hz.id_y_used),
    .ex_rf_wr(hz.ex_rf_wr), .ex_is_load(hz.ex_is_load),
    .wb_addr(hz.ex_wb_addr), .hazard(hazard)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // cnt counts remaining cycles of the current state; the state ends as it reaches zero
  assign last = cnt < 2'd2;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      RUN: begin
        state_n = hz.ex_br_taken ? BR_ST : hz.int_req ? INT_ST : RUN;
        cnt_n = hz.ex_br_taken ? FD1 : hz.int_req ? ID1 : cnt;
      end
      FLUSH: begin
        state_n = last ? RUN : FLUSH;
        cnt_n = cnt - 2'd1;
      end
      DRAIN: begin
        state_n = hz.ex_br_taken ? BR_ST : last ? INJECT : DRAIN;
        cnt_n = hz.ex_br_taken ? FD1 : cnt - 2'd1;
      end
      INJECT: state_n = REDIRECT;
      default: state_n = RUN;
    endcase
  end
  always_comb begin
    run_flush = (state == RUN) & hz.ex_br_taken;
    run_stall = (state == RUN) & ~hz.ex_br_taken & (hz.int_req | hazard);
    hz.stall_if = rst | run_stall | (state == DRAIN) | (state == INJECT);
    hz.flush_if_id = rst | run_flush | (state == FLUSH) | (state == REDIRECT);
    hz.nop_id_ex = rst | run_flush | run_stall | (state inside {FLUSH, DRAIN, REDIRECT});
    hz.int_inject = state == INJECT;
    hz.int_ack = state == INJECT;
    hz.busy = state != RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_count <= '0;
    else if (hz.stall_if && !(&stall_count)) stall_count <= stall_count + 1'b1;
  assign hz.stall_count = stall_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, corner sequences and random run against a schedule-queue model
module tb_pipeline_hazard_ctrl;
  import rat_pipe_pkg::*;
  localparam int FD = 2;
  localparam int ID = 2;
  localparam int K_FLUSH = 1, K_DRAIN = 2, K_INJECT = 3, K_REDIR = 4;
  typedef struct packed {
    logic [4:0] xa; logic xu; logic [4:0] ya; logic yu;
    logic wr; logic ld; logic [4:0] wb; logic br; logic irq;
  } in_t;
  typedef struct {
    in_t i;
    logic [5:0] e;
    string n;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int vectors = 0, errors = 0;
  int q[$];
  int unsigned m_cnt16 = 0, m_cnt4 = 0;
  vec_t tbl[10];
  pipeline_hazard_ctrl_if #(.CNT_W(16)) if1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4)) if4 ();
  assign if4.id_x_addr = if1.id_x_addr;
  assign if4.id_x_used = if1.id_x_used;
  assign if4.id_y_addr = if1.id_y_addr;
  assign if4.id_y_used = if1.id_y_used;
  assign if4.ex_rf_wr = if1.ex_rf_wr;
  assign if4.ex_is_load = if1.ex_is_load;
  assign if4.ex_wb_addr = if1.ex_wb_addr;
  assign if4.ex_br_taken = if1.ex_br_taken;
  assign if4.int_req = if1.int_req;
  pipeline_hazard_ctrl #(.FLUSH_DEPTH(FD), .INT_DRAIN(ID), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(if1));
  pipeline_hazard_ctrl #(.FLUSH_DEPTH(FD), .INT_DRAIN(ID), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .hz(if4));
  always #5 clk = ~clk;

  function automatic logic [5:0] act1();
    return {if1.stall_if, if1.flush_if_id, if1.nop_id_ex, if1.int_inject, if1.int_ack, if1.busy};
  endfunction
  function automatic logic [5:0] act4();
    return {if4.stall_if, if4.flush_if_id, if4.nop_id_ex, if4.int_inject, if4.int_ack, if4.busy};
  endfunction
  function automatic bit haz(in_t i);
    return i.wr && i.ld && ((i.xu && i.xa == i.wb) || (i.yu && i.ya == i.wb));
  endfunction
  // bits: stall_if flush_if_id nop_id_ex int_inject int_ack busy
  function automatic logic [5:0] model_out(in_t i);
    if (q.size() == 0) return i.br ? 6'b011000 : (i.irq || haz(i)) ? 6'b101000 : 6'b000000;
    case (q[0])
      K_FLUSH: return 6'b011001;
      K_DRAIN: return 6'b101001;
      K_INJECT: return 6'b100111;
      default: return 6'b011001;
    endcase
  endfunction
  function automatic void push_flush();
    for (int k = 0; k < FD - 1; k++) q.push_back(K_FLUSH);
  endfunction
  function automatic void model_advance(in_t i, logic [5:0] o);
    if (q.size() == 0) begin
      if (i.br) push_flush();
      else if (i.irq) begin
        for (int k = 0; k < ID - 1; k++) q.push_back(K_DRAIN);
        q.push_back(K_INJECT);
        q.push_back(K_REDIR);
      end
    end else if (q[0] == K_DRAIN && i.br) begin
      q.delete();
      push_flush();
    end else void'(q.pop_front());
    if (o[5]) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input in_t i);
    if1.id_x_addr = i.xa; if1.id_x_used = i.xu;
    if1.id_y_addr = i.ya; if1.id_y_used = i.yu;
    if1.ex_rf_wr = i.wr; if1.ex_is_load = i.ld; if1.ex_wb_addr = i.wb;
    if1.ex_br_taken = i.br; if1.int_req = i.irq;
  endtask
  task automatic apply(input in_t i, input string name, input bit use_exp, input logic [5:0] e);
    logic [5:0] m;
    drive(i);
    @(negedge clk);
    m = model_out(i);
    chk({name, "_model"}, 32'(act1()), 32'(m));
    if (use_exp) chk({name, "_tbl"}, 32'(act1()), 32'(e));
    chk({name, "_cnt4_out"}, 32'(act4()), 32'(m));
    chk({name, "_count16"}, 32'(if1.stall_count), m_cnt16);
    chk({name, "_count4"}, 32'(if4.stall_count), m_cnt4);
    model_advance(i, m);
    @(posedge clk);
    #1;
  endtask
  function automatic in_t mk(logic br, logic irq);
    in_t i = '0;
    i.br = br;
    i.irq = irq;
    return i;
  endfunction
  function automatic in_t mkh(logic [4:0] xa, logic xu, logic [4:0] ya, logic yu, logic wr, logic ld, logic [4:0] wb);
    in_t i = '0;
    i.xa = xa; i.xu = xu; i.ya = ya; i.yu = yu; i.wr = wr; i.ld = ld; i.wb = wb;
    return i;
  endfunction
  task automatic check_reset_outputs(input string name);
    chk({name, "_out"}, 32'(act1()), 32'(6'b111000));
    chk({name, "_count16"}, 32'(if1.stall_count), 0);
    chk({name, "_count4"}, 32'(if4.stall_count), 0);
  endtask

  initial begin
    in_t r;
    drive('0);
    tbl[0] = '{mkh(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0), 6'b000000, "idle"};
    tbl[1] = '{mkh(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5), 6'b101000, "lu_x"};
    tbl[2] = '{mkh(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5), 6'b000000, "not_load"};
    tbl[3] = '{mkh(5'd1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7), 6'b101000, "lu_y"};
    tbl[4] = '{mkh(5'd0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 5'd0), 6'b101000, "lu_r0"};
    tbl[5] = '{mkh(5'd5, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5), 6'b000000, "unused_src"};
    tbl[6] = '{mkh(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5), 6'b000000, "no_rf_wr"};
    tbl[7] = '{mkh(5'd5, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6), 6'b000000, "addr_diff"};
    tbl[8] = '{mkh(5'd9, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd9), 6'b000000, "x_unused_match"};
    tbl[9] = '{mkh(5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31), 6'b101000, "lu_both"};
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (tbl[k]) apply(tbl[k].i, tbl[k].n, 1'b1, tbl[k].e);
    // taken branch, including a second branch ignored while flushing
    apply(mk(1, 0), "br_run", 1, 6'b011000);
    apply(mk(0, 0), "br_flush", 1, 6'b011001);
    apply(mk(0, 0), "br_done", 1, 6'b000000);
    apply(mk(1, 0), "br2_run", 1, 6'b011000);
    apply(mk(1, 0), "br2_ignored", 1, 6'b011001);
    apply(mk(0, 0), "br2_done", 1, 6'b000000);
    // interrupt entry, request dropped after being sampled
    apply(mk(0, 1), "int_drain1", 1, 6'b101000);
    apply(mk(0, 0), "int_drain2", 1, 6'b101001);
    apply(mk(0, 0), "int_inject", 1, 6'b100111);
    apply(mk(0, 0), "int_redirect", 1, 6'b011001);
    apply(mk(0, 0), "int_run", 1, 6'b000000);
    // branch aborts a drain; held request then completes
    apply(mk(0, 1), "abort_drain1", 1, 6'b101000);
    apply(mk(1, 1), "abort_br", 1, 6'b101001);
    apply(mk(0, 1), "abort_flush", 1, 6'b011001);
    apply(mk(0, 1), "reint_drain1", 1, 6'b101000);
    apply(mk(0, 1), "reint_drain2", 1, 6'b101001);
    apply(mk(0, 1), "reint_inject", 1, 6'b100111);
    apply(mk(0, 0), "reint_redirect", 1, 6'b011001);
    apply(mk(0, 0), "reint_run", 1, 6'b000000);
    // branch beats interrupt and hazard
    r = tbl[1].i;
    r.br = 1'b1;
    r.irq = 1'b1;
    apply(r, "prio_all", 1, 6'b011000);
    apply(mk(0, 0), "prio_flush", 1, 6'b011001);
    apply(mk(0, 0), "prio_run", 1, 6'b000000);
    for (int k = 0; k < 20; k++) apply(tbl[1].i, "sat_hazard", 1, 6'b101000);
    apply(mk(0, 0), "sat_idle", 1, 6'b000000);
    chk("sat_count4", 32'(if4.stall_count), 15);
    // reset mid-drain drops the interrupt
    apply(mk(0, 1), "rst_drain1", 1, 6'b101000);
    rst = 1'b1;
    #2;
    check_reset_outputs("rst_mid_drain");
    drive('0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_cnt16 = 0;
    m_cnt4 = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) apply(mk(0, 0), "rst_no_ack", 1, 6'b000000);
    for (int k = 0; k < 600; k++) begin
      r.xa = 5'($urandom_range(0, 3));
      r.ya = 5'($urandom_range(0, 3));
      r.wb = 5'($urandom_range(0, 3));
      r.xu = 1'($urandom);
      r.yu = 1'($urandom);
      r.wr = 1'($urandom);
      r.ld = 1'($urandom);
      r.br = ($urandom_range(0, 7) == 0);
      r.irq = ($urandom_range(0, 5) == 0);
      apply(r, "rand", 0, 6'b000000);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
